// File: rtl/flit_source.sv
// Randomised packet traffic source for one credit-flow-controlled router input channel.
// Optional: define FLIT_SOURCE_ERROR_CHECK_EN to flag and drop credit overflows.
module flit_source #(
    parameter int initial_seed       = 0,
    parameter int inject_rate        = 50,
    parameter int buffer_size        = 64,
    parameter int num_vcs            = 8,
    parameter int max_payload_length = 4,
    parameter int min_payload_length = 1,
    parameter int route_info_width   = 14,
    parameter int enable_link_pm     = 1,
    parameter int flit_data_width    = 64,
    localparam int vc_idx_width      = (num_vcs > 1) ? $clog2(num_vcs) : 1,
    localparam int flow_ctrl_width   = 1 + vc_idx_width,
    localparam int channel_width     = enable_link_pm + 2 + vc_idx_width + flit_data_width
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    output logic [channel_width-1:0]   channel,
    input  logic [flow_ctrl_width-1:0] flow_ctrl,
    output logic [31:0]                packets_sent,
    output logic                       error
);
    localparam int credits_per_vc       = buffer_size / num_vcs;
    localparam int credit_width         = $clog2(credits_per_vc + 1);
    localparam int len_range            = max_payload_length - min_payload_length + 1;
    localparam int payload_length_width = (len_range > 1) ? $clog2(len_range) : 1;
    localparam int seq_field_width      = flit_data_width - route_info_width - payload_length_width;
    localparam int rem_width            = $clog2(max_payload_length + 1);
    localparam logic [credit_width-1:0] credits_full = credit_width'(credits_per_vc);
    localparam logic [vc_idx_width-1:0] last_vc      = vc_idx_width'(num_vcs - 1);
    localparam logic [63:0]             rng_seed     = 64'(initial_seed) ^ 64'h9E37_79B9_7F4A_7C15;

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t                        state, state_next;
    logic [63:0]                   rng;
    logic [vc_idx_width-1:0]       vc_q, rr_ptr, pick_vc;
    logic [rem_width-1:0]          len_q, remaining, pick_len;
    logic [route_info_width-1:0]   route_q, route_draw;
    logic [flit_data_width-1:0]    seq, head_data;
    logic [payload_length_width-1:0] len_field;
    logic [credit_width-1:0]       credits [num_vcs];
    logic [num_vcs-1:0]            credit_inc, credit_dec;
    logic                          ch_valid, ch_head;
    logic [vc_idx_width-1:0]       ch_vc;
    logic [flit_data_width-1:0]    ch_data;
    logic [15:0]                   draw;
    logic                          draw_pass, found, has_credit, start, send, tail;
    logic                          credit_valid;
    logic [vc_idx_width-1:0]       credit_vc;
    int                            idx;

    function automatic logic [63:0] xorshift64(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    assign credit_valid = flow_ctrl[flow_ctrl_width-1];
    assign credit_vc    = flow_ctrl[vc_idx_width-1:0];

    // One free-running generator feeds the gate draw, the length draw and the route field.
    assign draw       = rng[15:0] % 16'd100;
    assign draw_pass  = draw < 16'(inject_rate);
    assign pick_len   = rem_width'(min_payload_length + int'(rng[23:16]) % len_range);
    assign route_draw = route_info_width'(rng[63:24]);
    assign len_field  = payload_length_width'(int'(len_q) - min_payload_length);
    assign head_data  = {seq[seq_field_width-1:0], len_field, route_q};
    assign has_credit = credits[vc_q] != '0;

    // Round-robin search for the first VC with credit, starting at the pointer.
    always_comb begin
        found   = 1'b0;
        pick_vc = '0;
        idx     = 0;
        for (int i = 0; i < num_vcs; i++) begin
            idx = (int'(rr_ptr) + i) % num_vcs;
            if (!found && credits[idx] != '0) begin
                found   = 1'b1;
                pick_vc = vc_idx_width'(idx);
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        send       = 1'b0;
        case (state)
            IDLE: if (enable && draw_pass && found) begin
                start      = 1'b1;
                state_next = HEAD;
            end
            HEAD: if (has_credit && draw_pass) begin
                send       = 1'b1;
                state_next = BODY;
            end
            BODY: if (has_credit && draw_pass) begin
                send = 1'b1;
                if (remaining == rem_width'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign tail = send && (state == BODY) && (remaining == rem_width'(1));

`ifdef FLIT_SOURCE_ERROR_CHECK_EN
    logic overflow, error_q;
`endif

    always_comb begin
`ifdef FLIT_SOURCE_ERROR_CHECK_EN
        overflow = 1'b0;
`endif
        for (int v = 0; v < num_vcs; v++) begin
            credit_dec[v] = send && (vc_q == vc_idx_width'(v));
            credit_inc[v] = credit_valid && (credit_vc == vc_idx_width'(v));
`ifdef FLIT_SOURCE_ERROR_CHECK_EN
            if (credit_inc[v] && credits[v] == credits_full) begin
                overflow      = 1'b1;
                credit_inc[v] = 1'b0;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rng          <= rng_seed;
            vc_q         <= '0;
            rr_ptr       <= '0;
            len_q        <= '0;
            route_q      <= '0;
            remaining    <= '0;
            seq          <= '0;
            ch_valid     <= 1'b0;
            ch_vc        <= '0;
            ch_head      <= 1'b0;
            ch_data      <= '0;
            packets_sent <= '0;
            // NOTE: the credit array is a handful of flops, not RAM, so it is reset with the rest.
            for (int v = 0; v < num_vcs; v++) credits[v] <= credits_full;
        end else begin
            state <= state_next;
            rng   <= xorshift64(rng);
            if (start) begin
                vc_q    <= pick_vc;
                rr_ptr  <= (pick_vc == last_vc) ? '0 : pick_vc + 1'b1;
                len_q   <= pick_len;
                route_q <= route_draw;
            end
            if (send) begin
                seq       <= seq + 1'b1;
                remaining <= (state == HEAD) ? len_q : remaining - 1'b1;
            end
            ch_valid <= send;
            ch_vc    <= send ? vc_q : '0;
            ch_head  <= send && (state == HEAD);
            ch_data  <= !send ? '0 : ((state == HEAD) ? head_data : seq);
            if (tail) packets_sent <= packets_sent + 32'd1;
            for (int v = 0; v < num_vcs; v++) begin
                if (credit_inc[v] && !credit_dec[v])      credits[v] <= credits[v] + 1'b1;
                else if (!credit_inc[v] && credit_dec[v]) credits[v] <= credits[v] - 1'b1;
            end
        end
    end

`ifdef FLIT_SOURCE_ERROR_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) error_q <= 1'b0;
        else if ((credit_valid && int'(credit_vc) >= num_vcs) || overflow) error_q <= 1'b1;
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    generate
        if (enable_link_pm != 0) begin : g_link_pm
            assign channel = {(state != IDLE) || ch_valid, ch_valid, ch_vc, ch_head, ch_data};
        end else begin : g_no_link_pm
            assign channel = {ch_valid, ch_vc, ch_head, ch_data};
        end
    endgenerate
endmodule
